// File: rtl/digit_sequence_game.sv
// digit_sequence_game: memory game that grows a random digit sequence, replays it
// with show/gap timing, then checks the player's key entries against it.
module digit_sequence_game #(
    parameter int MAX_LEN     = 8,
    parameter int SHOW_CYCLES = 12000000,
    parameter int GAP_CYCLES  = 3000000,
    parameter int TMR_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rnd,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] digit_out,
    output logic       digit_en,
    output logic       input_ready,
    output logic [3:0] level,
    output logic       win,
    output logic       lose
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
    localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, ADD, SHOW, GAP, INPUT, WIN, LOSE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       play_idx_q, play_idx_d;
    logic [3:0]       in_idx_q, in_idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       mem_q [MAX_LEN];
    logic [3:0]       rnd_s;
    logic [3:0]       last_idx;
    logic [3:0]       want;

    assign rnd_s    = (rnd > 4'd9) ? rnd - 4'd10 : rnd;
    assign last_idx = len_q - 4'd1;
    assign want     = mem_q[in_idx_q[IW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            play_idx_q <= '0;
            in_idx_q   <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            play_idx_q <= play_idx_d;
            in_idx_q   <= in_idx_d;
            timer_q    <= timer_d;
        end
    end

    // Sequence storage needs no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (state_q == ADD && !start)
            mem_q[len_q[IW-1:0]] <= rnd_s;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        play_idx_d = play_idx_q;
        in_idx_d   = in_idx_q;
        timer_d    = timer_q;
        if (start) begin
            len_d   = '0;
            state_d = ADD;
        end else begin
            case (state_q)
                ADD: begin
                    len_d      = len_q + 4'd1;
                    play_idx_d = '0;
                    timer_d    = '0;
                    state_d    = SHOW;
                end
                SHOW: begin
                    timer_d = (timer_q == SHOW_LAST) ? '0 : timer_q + 1'b1;
                    state_d = (timer_q == SHOW_LAST) ? GAP : SHOW;
                end
                GAP: begin
                    timer_d = (timer_q == GAP_LAST) ? '0 : timer_q + 1'b1;
                    if (timer_q == GAP_LAST) begin
                        if (play_idx_q == last_idx) begin
                            in_idx_d = '0;
                            state_d  = INPUT;
                        end else begin
                            play_idx_d = play_idx_q + 4'd1;
                            state_d    = SHOW;
                        end
                    end
                end
                INPUT: begin
                    if (key_valid) begin
                        if (key_digit != want)
                            state_d = LOSE;
                        else if (in_idx_q == last_idx)
                            state_d = (len_q == LEN_MAX) ? WIN : ADD;
                        else
                            in_idx_d = in_idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digit_en    = (state_q == SHOW) || (state_q == LOSE);
    assign digit_out   = (state_q == SHOW) ? mem_q[play_idx_q[IW-1:0]] :
                         (state_q == LOSE) ? want : 4'd0;
    assign input_ready = (state_q == INPUT);
    assign level       = len_q;
    assign win         = (state_q == WIN);
    assign lose        = (state_q == LOSE);
endmodule

// File: tb/tb_digit_sequence_game.sv
// tb_digit_sequence_game: directed scenarios for digit_sequence_game with
// MAX_LEN=3, SHOW_CYCLES=3, GAP_CYCLES=2.
module tb_digit_sequence_game;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rnd = 4'd0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic [3:0] digit_out;
    logic       digit_en;
    logic       input_ready;
    logic [3:0] level;
    logic       win;
    logic       lose;
    int         tests = 0;
    int         fails = 0;

    digit_sequence_game #(.MAX_LEN(3), .SHOW_CYCLES(3), .GAP_CYCLES(2), .TMR_W(4)) dut (
        .clk(clk), .reset(reset), .rnd(rnd), .start(start),
        .key_valid(key_valid), .key_digit(key_digit),
        .digit_out(digit_out), .digit_en(digit_en), .input_ready(input_ready),
        .level(level), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Ends in the first SHOW cycle of round 1.
    task automatic start_game(input logic [3:0] r);
        rnd = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        key_digit = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Entered in the first SHOW cycle; ends in the first INPUT cycle.
    task automatic test_playback(input string name, input logic [11:0] seq, input int n);
        logic [3:0] d;
        for (int i = 0; i < n; i++) begin
            d = seq[4*i +: 4];
            for (int c = 0; c < 3; c++) begin
                tests++;
                if ({digit_en, digit_out, input_ready} !== {1'b1, d, 1'b0}) begin
                    fails++;
                    $display("FAIL %s show d%0d c%0d: en/out/rdy=%b/%0d/%b want 1/%0d/0",
                             name, i, c, digit_en, digit_out, input_ready, d);
                end
                @(negedge clk);
            end
            for (int c = 0; c < 2; c++) begin
                tests++;
                if ({digit_en, digit_out, input_ready} !== {1'b0, 4'd0, 1'b0}) begin
                    fails++;
                    $display("FAIL %s gap d%0d c%0d: en/out/rdy=%b/%0d/%b want 0/0/0",
                             name, i, c, digit_en, digit_out, input_ready);
                end
                @(negedge clk);
            end
        end
        tests++;
        if ({input_ready, digit_en} !== 2'b10) begin
            fails++;
            $display("FAIL %s ready: rdy/en=%b/%b want 1/0", name, input_ready, digit_en);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({digit_out, digit_en, input_ready, level, win, lose} !== 12'h0) begin
            fails++;
            $display("FAIL reset outputs: got %h want 000",
                     {digit_out, digit_en, input_ready, level, win, lose});
        end
        key_digit = 4'd0;
        @(negedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        tests++;
        if ({digit_out, digit_en, input_ready, level, win, lose} !== 12'h0) begin
            fails++;
            $display("FAIL idle keys ignored: got %h want 000",
                     {digit_out, digit_en, input_ready, level, win, lose});
        end
    endtask

    task automatic test_round1;
        start_game(4'd7);
        tests++;
        if (level !== 4'd1) begin
            fails++;
            $display("FAIL round1 level: got %0d want 1", level);
        end
        test_playback("round1", 12'h007, 1);
    endtask

    task automatic test_sanitise;
        start_game(4'd13);
        test_playback("sanitise13", 12'h003, 1);
        rnd = 4'd9;
        press(4'd3);
        @(negedge clk);
        test_playback("sanitise9", 12'h093, 2);
    endtask

    task automatic test_win;
        start_game(4'd7);
        test_playback("win r1", 12'h007, 1);
        rnd = 4'd2;
        press(4'd7);
        tests++;
        if ({input_ready, level} !== {1'b0, 4'd1}) begin
            fails++;
            $display("FAIL win add: rdy/level=%b/%0d want 0/1", input_ready, level);
        end
        @(negedge clk);
        tests++;
        if (level !== 4'd2) begin
            fails++;
            $display("FAIL win level2: got %0d want 2", level);
        end
        test_playback("win r2", 12'h027, 2);
        rnd = 4'd5;
        press(4'd7);
        tests++;
        if (input_ready !== 1'b1) begin
            fails++;
            $display("FAIL win mid-entry ready: got %b want 1", input_ready);
        end
        press(4'd2);
        @(negedge clk);
        tests++;
        if (level !== 4'd3) begin
            fails++;
            $display("FAIL win level3: got %0d want 3", level);
        end
        test_playback("win r3", 12'h527, 3);
        press(4'd7);
        press(4'd2);
        press(4'd5);
        tests++;
        if ({win, lose, input_ready, digit_en, level} !== {4'b1000, 4'd3}) begin
            fails++;
            $display("FAIL win state: win/lose/rdy/en/level=%b/%b/%b/%b/%0d want 1/0/0/0/3",
                     win, lose, input_ready, digit_en, level);
        end
        press(4'd1);
        @(negedge clk);
        tests++;
        if ({win, lose, level} !== {2'b10, 4'd3}) begin
            fails++;
            $display("FAIL win sticky: win/lose/level=%b/%b/%0d want 1/0/3", win, lose, level);
        end
    endtask

    task automatic test_loss;
        rnd = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({win, level} !== {1'b0, 4'd0}) begin
            fails++;
            $display("FAIL start clears win: win/level=%b/%0d want 0/0", win, level);
        end
        @(negedge clk);
        test_playback("loss r1", 12'h007, 1);
        rnd = 4'd2;
        press(4'd7);
        @(negedge clk);
        test_playback("loss r2", 12'h027, 2);
        press(4'd7);
        press(4'd4);
        tests++;
        if ({lose, win, digit_en, digit_out, input_ready} !== {3'b101, 4'd2, 1'b0}) begin
            fails++;
            $display("FAIL loss state: lose/win/en/out/rdy=%b/%b/%b/%0d/%b want 1/0/1/2/0",
                     lose, win, digit_en, digit_out, input_ready);
        end
        press(4'd2);
        tests++;
        if ({lose, win, digit_out} !== {2'b10, 4'd2}) begin
            fails++;
            $display("FAIL loss sticky: lose/win/out=%b/%b/%0d want 1/0/2", lose, win, digit_out);
        end
    endtask

    task automatic test_restart;
        start_game(4'd4);
        tests++;
        if ({lose, level, digit_out} !== {1'b0, 4'd1, 4'd4}) begin
            fails++;
            $display("FAIL restart from lose: lose/level/out=%b/%0d/%0d want 0/1/4",
                     lose, level, digit_out);
        end
        test_playback("restart r1", 12'h004, 1);
        rnd = 4'd6;
        press(4'd4);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({digit_en, digit_out, level} !== {1'b1, 4'd4, 4'd2}) begin
            fails++;
            $display("FAIL restart r2 show: en/out/level=%b/%0d/%0d want 1/4/2",
                     digit_en, digit_out, level);
        end
        rnd = 4'd1;
        key_digit = 4'd4;
        key_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key_valid = 1'b0;
        tests++;
        if ({digit_en, level, win, lose} !== {1'b0, 4'd0, 2'b00}) begin
            fails++;
            $display("FAIL restart add: en/level/win/lose=%b/%0d/%b/%b want 0/0/0/0",
                     digit_en, level, win, lose);
        end
        @(negedge clk);
        tests++;
        if ({level, digit_en, digit_out} !== {4'd1, 1'b1, 4'd1}) begin
            fails++;
            $display("FAIL restart show: level/en/out=%0d/%b/%0d want 1/1/1",
                     level, digit_en, digit_out);
        end
        test_playback("restart new", 12'h001, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({digit_out, digit_en, input_ready, level, win, lose} !== 12'h0) begin
            fails++;
            $display("FAIL reset in input: got %h want 000",
                     {digit_out, digit_en, input_ready, level, win, lose});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_round1;
        test_sanitise;
        test_win;
        test_loss;
        test_restart;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
